pb_conditioner: RTL and testbench

PB_CONDITIONER -- requirements
Module: pb_conditioner

---
 rtl/xidoo_pkg.sv | 15 +
 rtl/sync2.sv | 24 ++
 rtl/pb_conditioner.sv | 96 +++++++++
 tb/tb_pb_conditioner.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xidoo_pkg.sv
// Shared types and constants for the xidoo front-panel logic.
// Holds the push-button debouncer state encoding and its default debounce length.
package xidoo_pkg;

   // 10 ms at 50 MHz
   localparam int DEB_DEFAULT = 500000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } pb_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages clear to zero on reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pb_conditioner.sv
// Push-button conditioner: synchronizes Enter and SWT, debounces Enter, and emits one
// registered strobe per accepted press together with the switch value captured at that press.
module pb_conditioner
   import xidoo_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_DEFAULT
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic [7:0] SWT,
   input  logic      Enter,
   output logic [7:0] SWT_Q,
   output logic      EnterPulse,
   output logic      Held,
   output pb_state_t state_dbg
);

   localparam int CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic       enter_s;
   logic [7:0] swt_s;

   sync2 #(.W(1)) u_sync_enter (.clk(CLK), .rst(RST), .d(Enter), .q(enter_s));
   sync2 #(.W(8)) u_sync_swt   (.clk(CLK), .rst(RST), .d(SWT),   .q(swt_s));

   pb_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic          accept;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (enter_s) begin
               cnt_nxt   = CNT_ONE;
               state_nxt = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (!enter_s) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               accept    = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         PRESSED: begin
            if (!enter_s) begin
               cnt_nxt   = CNT_ONE;
               state_nxt = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            // a high sample here is release bounce: back to PRESSED without a new strobe
            if (enter_s) begin
               state_nxt = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = RELEASE_WAIT;
      endcase
   end

   // Reset lands in RELEASE_WAIT so a button held through reset must be released first.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= RELEASE_WAIT;
         cnt        <= '0;
         EnterPulse <= 1'b0;
         SWT_Q      <= 8'h00;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         EnterPulse <= accept;
         if (accept) begin
            SWT_Q <= swt_s;
         end
      end
   end

   assign Held      = (state == PRESSED) || (state == RELEASE_WAIT);
   assign state_dbg = state;

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner with DEB_CYCLES=4: directed scenarios plus random bouncing,
// every cycle checked against a run-length reference model of the debouncer.
module tb_pb_conditioner;
   import xidoo_pkg::*;

   localparam int DEB = 4;

   logic       clk;
   logic       rst;
   logic [7:0] swt;
   logic       enter;
   logic [7:0] swt_q;
   logic       enter_pulse;
   logic       held;
   pb_state_t  state_dbg;

   int n_vec = 0;
   int n_err = 0;

   pb_conditioner #(.DEB_CYCLES(DEB)) dut (
      .CLK(clk), .RST(rst), .SWT(swt), .Enter(enter),
      .SWT_Q(swt_q), .EnterPulse(enter_pulse), .Held(held), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference model: inputs are seen two edges late; the accepted level flips after DEB
   // consecutive opposite samples, and a low-to-high flip emits the strobe and captures SWT.
   logic       m_h1, m_h2;
   logic [7:0] m_w1, m_w2;
   int         run_hi, run_lo;
   logic       m_level;
   logic       exp_pulse;
   logic [7:0] exp_swtq;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_h1 = 0; m_h2 = 0; m_w1 = 0; m_w2 = 0;
         run_hi = 0; run_lo = 0; m_level = 1; exp_pulse = 0; exp_swtq = 8'h00;
      end else begin
         exp_pulse = 0;
         if (!m_level) begin
            if (m_h2) begin
               run_hi++;
               if (run_hi == DEB) begin
                  m_level = 1; exp_pulse = 1; exp_swtq = m_w2; run_lo = 0;
               end
            end else run_hi = 0;
         end else begin
            if (!m_h2) begin
               run_lo++;
               if (run_lo == DEB) begin
                  m_level = 0; run_hi = 0;
               end
            end else run_lo = 0;
         end
         m_h2 = m_h1; m_h1 = enter; m_w2 = m_w1; m_w1 = swt;
      end
   end

   task automatic test_reset();
      rst = 1; enter = 0; swt = 8'h00;
      #1;
      n_vec++;
      if (enter_pulse !== 1'b0 || held !== 1'b1 || swt_q !== 8'h00 || state_dbg !== RELEASE_WAIT) begin
         n_err++;
         $display("FAIL reset_values: pulse=%b held=%b swt_q=%h state=%0d, expected 0 1 00 %0d",
                  enter_pulse, held, swt_q, state_dbg, RELEASE_WAIT);
      end
      #99;
      rst = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL reset_release cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (state_dbg !== IDLE) begin
         n_err++;
         $display("FAIL reset_settle_idle: state=%0d, expected %0d", state_dbg, IDLE);
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      swt = 8'h0F;
      for (int i = 0; i < 10; i++) begin
         enter = (i < 2);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) pulses++;
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL glitch cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 0 || swt_q !== 8'h00) begin
         n_err++;
         $display("FAIL glitch_result: pulses=%0d swt_q=%h, expected 0 00", pulses, swt_q);
      end
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      int first = -1;
      swt = 8'h06;
      for (int i = 0; i < 18; i++) begin
         enter = (i < 10);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) begin
            pulses++;
            if (first < 0) first = i + 1;
         end
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL clean cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 1 || first !== 6 || swt_q !== 8'h06) begin
         n_err++;
         $display("FAIL clean_result: pulses=%0d at_negedge=%0d swt_q=%h, expected 1 6 06",
                  pulses, first, swt_q);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int first = -1;
      swt = 8'hA5;
      for (int i = 0; i < 22; i++) begin
         enter = (i < 4) ? ((i % 2) == 0) : (i < 14);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) begin
            pulses++;
            if (first < 0) first = i + 1;
         end
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL bounce cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 1 || first !== 10 || swt_q !== 8'hA5) begin
         n_err++;
         $display("FAIL bounce_result: pulses=%0d at_negedge=%0d swt_q=%h, expected 1 10 a5",
                  pulses, first, swt_q);
      end
   endtask

   task automatic test_two_presses();
      int pulses = 0;
      logic [7:0] cap [2];
      cap[0] = 8'h00; cap[1] = 8'h00;
      for (int i = 0; i < 36; i++) begin
         swt   = (i < 18) ? 8'h06 : 8'h0F;
         enter = (i < 8) || (i >= 18 && i < 26);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) begin
            if (pulses < 2) cap[pulses] = swt_q;
            pulses++;
         end
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL two_press cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 2 || cap[0] !== 8'h06 || cap[1] !== 8'h0F) begin
         n_err++;
         $display("FAIL two_press_result: pulses=%0d swt_q=%h,%h, expected 2 06,0f",
                  pulses, cap[0], cap[1]);
      end
   endtask

   task automatic test_release_bounce();
      int pulses = 0;
      int held_tail = 0;
      swt = 8'h3C;
      for (int i = 0; i < 24; i++) begin
         enter = (i < 8) || (i == 10);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) pulses++;
         if (i >= 11 && held) held_tail++;
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL rel_bounce cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 1 || held_tail !== 5 || held !== 1'b0) begin
         n_err++;
         $display("FAIL rel_bounce_result: pulses=%0d held_cycles=%0d held=%b, expected 1 5 0",
                  pulses, held_tail, held);
      end
   endtask

   task automatic test_reset_held();
      int pulses_held = 0;
      int pulses_after = 0;
      swt = 8'h81;
      enter = 1;
      rst = 1;
      for (int i = 0; i < 29; i++) begin
         if (i == 3) rst = 0;
         enter = (i < 16) || (i >= 21);
         @(negedge clk);
         n_vec++;
         if (enter_pulse) begin
            if (i < 21) pulses_held++;
            else pulses_after++;
         end
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL reset_held cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses_held !== 0 || pulses_after !== 1 || swt_q !== 8'h81) begin
         n_err++;
         $display("FAIL reset_held_result: held_pulses=%0d later_pulses=%0d swt_q=%h, expected 0 1 81",
                  pulses_held, pulses_after, swt_q);
      end
      enter = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int found = 0;
      int pulses = 0;
      swt = 8'h55;
      enter = 1;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (enter_pulse) found = 1;
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL abort_no_pulse: no strobe within 12 cycles, expected one");
      end
      rst = 1;
      #1;
      n_vec++;
      if (enter_pulse !== 1'b0 || swt_q !== 8'h00 || held !== 1'b1) begin
         n_err++;
         $display("FAIL abort_async: pulse=%b swt_q=%h held=%b, expected 0 00 1",
                  enter_pulse, swt_q, held);
      end
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (enter_pulse) pulses++;
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL abort cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      n_vec++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL abort_result: pulses=%0d after reset release, expected 0", pulses);
      end
      enter = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      int run = 0;
      for (int i = 0; i < 800; i++) begin
         if (run == 0) begin
            enter = ~enter;
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
         end
         run--;
         swt = 8'($urandom_range(0, 255));
         rst = ($urandom_range(0, 249) == 0);
         @(negedge clk);
         n_vec++;
         if (enter_pulse !== exp_pulse || held !== m_level || swt_q !== exp_swtq) begin
            n_err++;
            $display("FAIL random cyc%0d: pulse=%b held=%b swt_q=%h, expected %b %b %h",
                     i, enter_pulse, held, swt_q, exp_pulse, m_level, exp_swtq);
         end
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_clean_press();
      test_bounce();
      test_two_presses();
      test_release_bounce();
      test_reset_held();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
